// File: rtl/aes_column_seq_pkg.sv
// Shared types and constants for the AES forward-round column sequencer.
package aes_column_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_seq_state_e;

    // Byte select of the final aes_unit pass; the step counter wraps after it.
    localparam logic [1:0] LAST_STEP = 2'd3;

endpackage

// File: rtl/aes_column_seq.sv
// Drives the single-byte aes_unit four times (bs = 0..3) to build one full
// AES forward-round output column, then offers it over a valid/ready handshake.
module aes_column_seq
    import aes_column_seq_pkg::*;
#(
    parameter bit LOGIC_GATING = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    output logic         ready_o,
    input  logic [31:0]  rk_i,
    input  logic [127:0] state_i,
    input  logic [1:0]   col_i,
    input  logic         mix_i,
    input  logic         flush_i,
    output logic         busy_o,
    output logic         result_valid_o,
    input  logic         result_ready_i,
    output logic [31:0]  result_o,
    output logic [31:0]  aes_rs1_o,
    output logic [31:0]  aes_rs2_o,
    output logic [1:0]   aes_bs_o,
    output logic         aes_mix_o,
    output logic         aes_valid_o,
    input  logic [31:0]  aes_rd_i
);

    aes_seq_state_e state_q, state_d;
    logic [31:0]    acc_q;
    logic [1:0]     step_q;
    logic [127:0]   words_q;
    logic [1:0]     col_q;
    logic           mix_q;

    logic           accept;
    logic           in_run;
    logic           gate_ops;
    logic [31:0]    cur_word;

    // ShiftRows: step k works on byte k of word (c + k) mod 4; the 2-bit add wraps.
    function automatic logic [31:0] sel_word(input logic [127:0] words,
                                             input logic [1:0]   col,
                                             input logic [1:0]   step);
        logic [1:0] idx;
        idx = col + step;
        return words[{idx, 5'd0} +: 32];
    endfunction

    assign in_run   = (state_q == RUN);
    assign ready_o  = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && result_ready_i));
    assign accept   = start_i && ready_o;
    assign cur_word = sel_word(words_q, col_q, step_q);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (step_q == LAST_STEP) state_d = DONE;
            DONE:    if (result_ready_i) state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the operand copy is a plain register bank, not a memory, so it is cleared with the rest of the state.
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            words_q <= '0;
            col_q   <= '0;
            mix_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q   <= rk_i;
                words_q <= state_i;
                col_q   <= col_i;
                mix_q   <= mix_i;
                step_q  <= '0;
            end else if (in_run) begin
                acc_q  <= aes_rd_i;
                step_q <= step_q + 2'd1;
            end
        end
    end

    // Gated builds hold the aes_unit operands at zero outside RUN to stop toggling.
    assign gate_ops = LOGIC_GATING && !in_run;

    assign aes_rs1_o   = gate_ops ? 32'd0 : acc_q;
    assign aes_rs2_o   = gate_ops ? 32'd0 : cur_word;
    assign aes_bs_o    = gate_ops ? 2'd0  : step_q;
    assign aes_mix_o   = gate_ops ? 1'b0  : mix_q;
    assign aes_valid_o = in_run;

    assign busy_o         = (state_q != IDLE);
    assign result_valid_o = (state_q == DONE);
    assign result_o       = acc_q;

endmodule
